// File: rtl/shot_clock_pkg.sv
// Shared types and defaults for the shot clock.
// State encoding and parameter defaults live here.
package shot_clock_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUZZ = 1'b1
  } state_t;

  localparam int CNT_W        = 4;
  localparam int START_DEF    = 10;
  localparam int TICK_DIV_DEF = 4;
  localparam int BUZZ_LEN_DEF = 3;

endpackage

// File: rtl/shot_clock_if.sv
// Output bundle of the shot clock.
// master drives, slave observes.
interface shot_clock_if;
  import shot_clock_pkg::*;

  logic [CNT_W-1:0] count;
  logic             shoot;
  logic             buzz;

  modport master (
    output count,
    output shoot,
    output buzz
  );

  modport slave (
    input count,
    input shoot,
    input buzz
  );

endinterface

// File: rtl/shot_clock_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled,
// tick is high on the last count.
module tick_gen
  import shot_clock_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shot_clock.sv
// Shot clock: counts down from START, pulses shoot on
// expiry, then buzzes for BUZZ_LEN clocks and reloads.
module shot_clock
  import shot_clock_pkg::*;
#(
  parameter int START    = START_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int BUZZ_LEN = BUZZ_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  shot_clock_if.master  sc
);

  localparam int BW =
    (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'(BUZZ_LEN - 1);
  localparam logic [CNT_W-1:0] START_V =
    CNT_W'(START);

  state_t           r_state;
  state_t           w_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count;
  logic [BW-1:0]    r_bcnt;
  logic [BW-1:0]    w_bcnt;
  logic             r_shoot;
  logic             w_shoot;
  logic             r_buzz;
  logic             w_buzz;
  logic             w_tick;
  logic             w_run;

  assign w_run = (r_state == RUN);

  // Prescaler wraps to 0 on the expiry tick and
  // holds while disabled, so RUN resumes from 0.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (w_run),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_count <= START_V;
      r_bcnt  <= '0;
      r_shoot <= 1'b0;
      r_buzz  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_bcnt  <= w_bcnt;
      r_shoot <= w_shoot;
      r_buzz  <= w_buzz;
    end
  end

  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_bcnt  = r_bcnt;
    w_shoot = 1'b0;
    w_buzz  = r_buzz;
    unique case (r_state)
      RUN: begin
        if (w_tick) begin
          if (r_count > CNT_W'(1)) begin
            w_count = r_count - 1'b1;
          end else begin
            w_count = '0;
            w_shoot = 1'b1;
            w_buzz  = 1'b1;
            w_bcnt  = '0;
            w_state = BUZZ;
          end
        end
      end
      BUZZ: begin
        if (r_bcnt == BLAST) begin
          w_count = START_V;
          w_buzz  = 1'b0;
          w_state = RUN;
        end else begin
          w_bcnt = r_bcnt + 1'b1;
        end
      end
    endcase
  end

  assign sc.count = r_count;
  assign sc.shoot = r_shoot;
  assign sc.buzz  = r_buzz;

endmodule

// File: tb/tb_shot_clock.sv
// Bench for shot_clock: default and minimal configs
// against a phase-arithmetic reference model.
module tb_shot_clock;

  logic clk;
  logic rst_n;
  int   t;
  int   n_chk;
  int   n_pass;
  int   n_shoot;

  shot_clock_if sc0 ();
  shot_clock_if sc1 ();

  shot_clock u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sc    (sc0.master)
  );

  shot_clock #(
    .START    (1),
    .TICK_DIV (1),
    .BUZZ_LEN (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sc    (sc1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0d got=%0d exp=%0d",
               tag, t, got, exp);
    end
  endtask

  // Expected outputs t edges after reset release.
  function automatic void model(
    input  int s,
    input  int td,
    input  int bl,
    input  int tt,
    output int c,
    output int sh,
    output int bz
  );
    int p;
    int ph;
    p  = s * td + bl;
    ph = tt % p;
    if (ph < s * td) begin
      c  = s - ph / td;
      sh = 0;
      bz = 0;
    end else begin
      c  = 0;
      sh = (ph == s * td) ? 1 : 0;
      bz = 1;
    end
  endfunction

  task automatic check_all();
    int c, sh, bz;
    model(10, 4, 3, t, c, sh, bz);
    check("cnt0", int'(sc0.count), c);
    check("sh0",  int'(sc0.shoot), sh);
    check("bz0",  int'(sc0.buzz),  bz);
    model(1, 1, 1, t, c, sh, bz);
    check("cnt1", int'(sc1.count), c);
    check("sh1",  int'(sc1.shoot), sh);
    check("bz1",  int'(sc1.buzz),  bz);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) t++;
    @(negedge clk);
    if (sc0.shoot) n_shoot++;
    check_all();
  endtask

  // Async reset between edges, checked before any edge.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    t     = 0;
    #1;
    check("arst_cnt0", int'(sc0.count), 10);
    check("arst_bz0",  int'(sc0.buzz),  0);
    check("arst_sh0",  int'(sc0.shoot), 0);
    check("arst_cnt1", int'(sc1.count), 1);
    check("arst_bz1",  int'(sc1.buzz),  0);
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    n_shoot = 0;
    t       = 0;
    rst_n   = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;

    repeat (90) step();
    check("shoots_2per", n_shoot, 2);

    // Land mid-buzz, then reset between edges.
    rst_n = 1'b0;
    t     = 0;
    step();
    rst_n = 1'b1;
    repeat (41) step();
    check("midbuzz_bz", int'(sc0.buzz), 1);
    async_reset(2);
    repeat (50) step();

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset($urandom_range(1, 3));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
